// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INST      : word presented to decode when IF/ID holds no instruction
//   RESET_PC_DEF  : default first fetch address after reset
//   fetch_state_t : fetch FSM states
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // issue when the queue has room
    WAIT  = 2'd1,  // request outstanding, hold address
    DRAIN = 2'd2   // request outstanding but made stale by a redirect
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/valid bus.
//   req   : fetch request (master -> memory)
//   addr  : word-aligned fetch address (master -> memory)
//   valid : response, completes the request in the cycle it is high
//   rdata : instruction word, valid with 'valid'
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             valid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, addr, input valid, rdata);
  modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} pairs between the memory
// response and the IF/ID register.
//   clk, start      : clock, synchronous active-low reset
//   clear           : drop all entries (redirect)
//   push/push_pc/push_inst : write one entry
//   pop             : retire the head entry
//   head_pc/head_inst : current head (meaningful when !empty)
//   count/empty/full : occupancy
module fetch_queue #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 2,
  localparam int AW = $clog2(QDEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             start,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_inst,
  input  logic             pop,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_inst,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] pc_mem   [QDEPTH];
  logic [WIDTH-1:0] inst_mem [QDEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // QDEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!start || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CW'(QDEPTH));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
//   clk, start      : clock, synchronous active-low reset
//   stall           : hold IF/ID (hazard unit)
//   branch_taken    : redirect + flush; branch_target low 2 bits ignored
//   imem            : request/valid instruction-memory bus (master side)
//   inst/pc_out/inst_valid : IF/ID register to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter int               QDEPTH   = 2,
  parameter logic [WIDTH-1:0] NOP      = NOP_INST
) (
  input  logic             clk,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  fetch_unit_if.master     imem,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc_out,
  output logic             inst_valid
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t     state, state_nxt;
  logic             run_en;     // low for the first cycle after reset
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_addr;   // address of the outstanding request
  logic             fire, push_in, adv, take_byp;
  logic             q_push, q_pop, q_empty, q_full;
  logic [WIDTH-1:0] q_pc, q_inst;
  logic [CW-1:0]    q_count;

  assign fire    = imem.req && imem.valid;
  // A response accepted into the stream; stale (DRAIN) or redirected ones are dropped.
  assign push_in = fire && (state != DRAIN) && !branch_taken;
  assign adv     = !branch_taken && !stall;
  assign q_pop   = adv && !q_empty;
  // Empty queue: the response goes straight into IF/ID, giving one-cycle latency.
  assign take_byp = adv && q_empty && push_in;
  assign q_push   = push_in && !take_byp && (!q_full || q_pop);

  always_ff @(posedge clk) begin
    if (!start) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem.req  = 1'b0;
    imem.addr = req_addr;
    unique case (state)
      RUN: begin
        imem.addr = fetch_pc;
        imem.req  = start && run_en && ((q_count < CW'(QDEPTH)) || q_pop);
        if (imem.req && !imem.valid) state_nxt = branch_taken ? DRAIN : WAIT;
      end
      WAIT: begin
        imem.req = start && run_en;
        if (imem.valid)        state_nxt = RUN;
        else if (branch_taken) state_nxt = DRAIN;
      end
      DRAIN: begin
        imem.req = start && run_en;
        if (imem.valid) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      run_en   <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      run_en <= 1'b1;
      // Latch the issued address so WAIT/DRAIN keep it even after fetch_pc is redirected.
      if (state == RUN) req_addr <= fetch_pc;
      if (branch_taken) fetch_pc <= {branch_target[WIDTH-1:2], 2'b00};
      else if (push_in) fetch_pc <= fetch_pc + WIDTH'(4);
    end
  end

  fetch_queue #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .start     (start),
    .clear     (branch_taken),
    .push      (q_push),
    .push_pc   (fetch_pc),
    .push_inst (imem.rdata),
    .pop       (q_pop),
    .head_pc   (q_pc),
    .head_inst (q_inst),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // IF/ID register: flush beats stall; idle keeps the last PC.
  always_ff @(posedge clk) begin
    if (!start || branch_taken) begin
      inst       <= NOP;
      pc_out     <= '0;
      inst_valid <= 1'b0;
    end else if (!stall) begin
      if (q_pop) begin
        inst       <= q_inst;
        pc_out     <= q_pc;
        inst_valid <= 1'b1;
      end else if (take_byp) begin
        inst       <= imem.rdata;
        pc_out     <= fetch_pc;
        inst_valid <= 1'b1;
      end else begin
        inst       <= NOP;
        inst_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hC0DE_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk, start, stall, branch_taken;
  logic [31:0] branch_target, inst, pc_out;
  logic        inst_valid;

  fetch_unit_if #(.WIDTH(32)) imem_bus ();

  fetch_unit dut (
    .clk           (clk),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .inst          (inst),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid)
  );

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nfire  = 0;
  int ws     = 0;
  int wcnt   = 0;
  logic [31:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: responds after ws wait cycles; data is the address tagged with KEY.
  assign imem_bus.valid = imem_bus.req && (wcnt >= ws);
  assign imem_bus.rdata = imem_bus.addr ^ KEY;
  initial forever @(posedge clk)
    wcnt <= (imem_bus.req && !imem_bus.valid) ? wcnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Scoreboard monitor: a new IF/ID entry is one loaded at an edge without stall.
  initial begin
    logic        stall_prev, req_prev, valid_prev;
    logic [31:0] addr_prev, e;
    stall_prev = 1'b0;
    req_prev   = 1'b0;
    valid_prev = 1'b0;
    addr_prev  = '0;
    forever begin
      @(negedge clk);
      if (imem_bus.req && imem_bus.valid) nfire++;
      if (req_prev && !valid_prev && imem_bus.req)
        chk("addr_stable", imem_bus.addr, addr_prev);
      if (inst_valid && !stall_prev) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %h, nothing expected", pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", pc_out, e);
          chk("sb_inst", inst, e ^ KEY);
        end
      end
      stall_prev = stall;
      req_prev   = imem_bus.req;
      valid_prev = imem_bus.valid;
      addr_prev  = imem_bus.addr;
    end
  end

  initial begin
    int n0, f0;
    logic [31:0] fz_inst, fz_pc;
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset state
    repeat (3) tick();
    chk1("rst_req", imem_bus.req, 1'b0);
    chk("rst_inst", inst, NOPW);
    chk("rst_pc", pc_out, 32'h0);
    chk1("rst_valid", inst_valid, 1'b0);

    // Zero-wait fetch from RESET_PC
    fill(32'h0, 200);
    start = 1'b1; #1;
    chk1("c0_req", imem_bus.req, 1'b0);
    tick();
    chk1("c1_req", imem_bus.req, 1'b1);
    chk("c1_addr", imem_bus.addr, 32'h0);
    chk1("c1_valid", inst_valid, 1'b0);
    tick();
    chk1("c2_valid", inst_valid, 1'b1);
    chk("c2_pc", pc_out, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("tput_valid", inst_valid, 1'b1);
    end

    // Three wait states: one instruction every four cycles
    ws = 3;
    repeat (4) tick();
    n0 = nvalid;
    repeat (24) tick();
    chk("ws3_count", 32'(nvalid - n0), 32'd6);

    // Stall five cycles with zero-wait memory
    ws = 0;
    repeat (4) tick();
    stall = 1'b1;
    fz_inst = inst; fz_pc = pc_out; f0 = nfire;
    chk1("stall_pre_valid", inst_valid, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("stall_inst", inst, fz_inst);
      chk("stall_pc", pc_out, fz_pc);
      chk1("stall_valid", inst_valid, 1'b1);
      if (k >= 2) chk1("stall_req_low", imem_bus.req, 1'b0);
    end
    tick();
    chk("stall_pushes", 32'(nfire - f0), 32'd2);
    stall = 1'b0;
    chk("stall_hold_last", pc_out, fz_pc);
    repeat (6) tick();

    // Redirect during WAIT: stale response dropped
    ws = 3;
    tick();
    chk1("wait_req", imem_bus.req, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    @(negedge clk); #1;
    fill(32'h0000_0100, 200);
    tick();
    branch_taken = 1'b0;
    chk1("redir_valid", inst_valid, 1'b0);
    chk("redir_inst", inst, NOPW);
    repeat (2) tick();
    chk1("tgt_req", imem_bus.req, 1'b1);
    chk("tgt_addr", imem_bus.addr, 32'h0000_0100);
    repeat (4) tick();
    chk1("tgt_valid", inst_valid, 1'b1);
    chk("tgt_pc", pc_out, 32'h0000_0100);
    repeat (6) tick();

    // Flush and stall together, then PC wrap
    ws = 0;
    repeat (4) tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    @(negedge clk); #1;
    fill(32'hFFFF_FFF8, 200);
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    chk("flush_inst", inst, NOPW);
    chk1("flush_valid", inst_valid, 1'b0);
    chk("flush_pc", pc_out, 32'h0);
    tick();
    chk("wrap_pc0", pc_out, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", pc_out, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", pc_out, 32'h0000_0000);
    chk1("wrap_valid", inst_valid, 1'b1);

    // Reset in the middle of a waited request
    ws = 3;
    repeat (2) tick();
    start = 1'b0; #1;
    chk1("rst2_req_now", imem_bus.req, 1'b0);
    tick();
    chk1("rst2_req", imem_bus.req, 1'b0);
    chk1("rst2_valid", inst_valid, 1'b0);
    chk("rst2_inst", inst, NOPW);
    chk("rst2_pc", pc_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
